// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard detection unit.
// Holds the x0 register index and the three control encodings.
package hazard_pkg;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic ctrl_mux_sel;
    logic if_flush;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_NORMAL = '{
    pc_write: 1'b1, if_id_write: 1'b1,
    ctrl_mux_sel: 1'b0, if_flush: 1'b0
  };

  localparam hazard_ctrl_t CTRL_STALL = '{
    pc_write: 1'b0, if_id_write: 1'b0,
    ctrl_mux_sel: 1'b1, if_flush: 1'b0
  };

  localparam hazard_ctrl_t CTRL_FLUSH = '{
    pc_write: 1'b1, if_id_write: 1'b1,
    ctrl_mux_sel: 1'b1, if_flush: 1'b1
  };

endpackage

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports: clk, rst, inc (count enable), count (W-bit value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and taken-branch flush detection with event counters.
// Ports: ID/EX hazard inputs, zero; PC/IF-ID control outputs; stall_cnt, flush_cnt.
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_RegisterRs1,
  input  logic [4:0]       IF_ID_RegisterRs2,
  input  logic [4:0]       ID_EX_RegisterRd,
  input  logic             ID_EX_MemRead,
  input  logic             zero,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ControlMuxSel,
  output logic             IF_Flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic         loadUse;
  logic         stallEvt;
  logic         flushEvt;
  hazard_ctrl_t ctrl;

  assign loadUse = ID_EX_MemRead
    && (ID_EX_RegisterRd != REG_X0)
    && ((ID_EX_RegisterRd == IF_ID_RegisterRs1)
     || (ID_EX_RegisterRd == IF_ID_RegisterRs2));

  // Flush wins over stall, so the stall event is masked by zero
  // and the two events are mutually exclusive.
  assign flushEvt = zero;
  assign stallEvt = !zero && loadUse;

  always_comb begin
    ctrl = CTRL_NORMAL;
    if (!rst) begin
      unique case (1'b1)
        flushEvt: ctrl = CTRL_FLUSH;
        stallEvt: ctrl = CTRL_STALL;
        default:  ctrl = CTRL_NORMAL;
      endcase
    end
  end

  assign PCWrite       = ctrl.pc_write;
  assign IF_ID_Write   = ctrl.if_id_write;
  assign ControlMuxSel = ctrl.ctrl_mux_sel;
  assign IF_Flush      = ctrl.if_flush;

  // Reset inside the counters drops the increment of a reset cycle.
  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stallEvt),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flushEvt),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed vector bench for hazard_detection_unit.
// Checks control encodings, counters, reset and saturation.
module tb_hazard_detection_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        memRead, zero;

  logic        pcW, ifidW, muxSel, ifFlush;
  logic [15:0] stallCnt, flushCnt;
  logic        pcW2, ifidW2, muxSel2, ifFlush2;
  logic [1:0]  stallCnt2, flushCnt2;

  int nVec = 0;
  int nErr = 0;

  always #5 clk = ~clk;

  hazard_detection_unit #(.CNT_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .IF_ID_RegisterRs1 (rs1),
    .IF_ID_RegisterRs2 (rs2),
    .ID_EX_RegisterRd  (rd),
    .ID_EX_MemRead     (memRead),
    .zero              (zero),
    .PCWrite           (pcW),
    .IF_ID_Write       (ifidW),
    .ControlMuxSel     (muxSel),
    .IF_Flush          (ifFlush),
    .stall_cnt         (stallCnt),
    .flush_cnt         (flushCnt)
  );

  hazard_detection_unit #(.CNT_W(2)) dutSmall (
    .clk               (clk),
    .rst               (rst),
    .IF_ID_RegisterRs1 (rs1),
    .IF_ID_RegisterRs2 (rs2),
    .ID_EX_RegisterRd  (rd),
    .ID_EX_MemRead     (memRead),
    .zero              (zero),
    .PCWrite           (pcW2),
    .IF_ID_Write       (ifidW2),
    .ControlMuxSel     (muxSel2),
    .IF_Flush          (ifFlush2),
    .stall_cnt         (stallCnt2),
    .flush_cnt         (flushCnt2)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       memRead, zero;
    logic [3:0] expCtrl;
    int         expStall, expFlush;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [4:0] a,
                       input logic [4:0] b, input logic [4:0] d,
                       input logic m, input logic z);
    rst = r; rs1 = a; rs2 = b; rd = d; memRead = m; zero = z;
  endtask

  function automatic vec_t mk(string n, logic r,
      logic [4:0] a, logic [4:0] b, logic [4:0] d,
      logic m, logic z, logic [3:0] c, int s, int f);
    vec_t v;
    v.name = n; v.rst = r; v.rs1 = a; v.rs2 = b; v.rd = d;
    v.memRead = m; v.zero = z; v.expCtrl = c;
    v.expStall = s; v.expFlush = f;
    return v;
  endfunction

  initial begin
    // ctrl = {PCWrite, IF_ID_Write, ControlMuxSel, IF_Flush}
    vecs.push_back(mk("rst_loaduse", 1, 1, 2, 1, 1, 0, 4'b1100, 0, 0));
    vecs.push_back(mk("rst_branch",  1, 1, 2, 3, 0, 1, 4'b1100, 0, 0));
    vecs.push_back(mk("no_hazard",   0, 1, 2, 3, 0, 0, 4'b1100, 0, 0));
    vecs.push_back(mk("branch",      0, 1, 2, 3, 0, 1, 4'b1111, 0, 1));
    vecs.push_back(mk("no_hazard2",  0, 1, 2, 3, 0, 0, 4'b1100, 0, 1));
    vecs.push_back(mk("lu_rs1_a",    0, 1, 2, 1, 1, 0, 4'b0010, 1, 1));
    vecs.push_back(mk("lu_rs1_b",    0, 1, 2, 1, 1, 0, 4'b0010, 2, 1));
    vecs.push_back(mk("lu_rs2",      0, 4, 7, 7, 1, 0, 4'b0010, 3, 1));
    vecs.push_back(mk("rd_no_load",  0, 6, 5, 6, 0, 0, 4'b1100, 3, 1));
    vecs.push_back(mk("rd_nl_br",    0, 6, 5, 6, 0, 1, 4'b1111, 3, 2));
    vecs.push_back(mk("load_x0",     0, 0, 5, 0, 1, 0, 4'b1100, 3, 2));
    vecs.push_back(mk("lu_and_br",   0, 1, 2, 1, 1, 1, 4'b1111, 3, 3));
    vecs.push_back(mk("rst_midstl",  1, 1, 2, 1, 1, 0, 4'b1100, 0, 0));
    vecs.push_back(mk("lu_after",    0, 1, 2, 1, 1, 0, 4'b0010, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rs1, vecs[i].rs2,
            vecs[i].rd, vecs[i].memRead, vecs[i].zero);
      #1;
      check({vecs[i].name, "_ctrl"},
            {28'd0, pcW, ifidW, muxSel, ifFlush},
            {28'd0, vecs[i].expCtrl});
      @(posedge clk);
      #1;
      check({vecs[i].name, "_stall_cnt"},
            {16'd0, stallCnt}, vecs[i].expStall);
      check({vecs[i].name, "_flush_cnt"},
            {16'd0, flushCnt}, vecs[i].expFlush);
    end

    // Stall saturation on the 2-bit instance.
    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("small_rst_stall", {30'd0, stallCnt2}, 0);
    check("small_rst_flush", {30'd0, flushCnt2}, 0);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 2, 1, 1, 0);
      #1;
      check("small_stall_ctrl",
            {28'd0, pcW2, ifidW2, muxSel2, ifFlush2}, 4'b0010);
      @(posedge clk); #1;
      check("small_stall_cnt", {30'd0, stallCnt2},
            (i > 3) ? 3 : i);
    end
    check("big_stall_5", {16'd0, stallCnt}, 5);

    // Flush saturation, stall count held.
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, 2, 1, 1, 1);
      @(posedge clk); #1;
      check("small_flush_cnt", {30'd0, flushCnt2},
            (i > 3) ? 3 : i);
    end
    check("small_stall_hold", {30'd0, stallCnt2}, 3);
    check("big_flush_4", {16'd0, flushCnt}, 4);

    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nErr);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Pipeline hazard detector for the 5-stage RISC-V core, sitting between the IF/ID and ID/EX pipeline registers.
- Detects load-use data hazards and stalls the front end for one bubble.
- Detects taken branches, signalled by the ALU `zero` flag, and flushes the wrong-path instruction.
- Keeps saturating event counters for stalls and flushes so that performance can be observed.

## Interface
Parameters:
- CNT_W, 16, width of each event counter.

Ports:
- clk  input  1  system clock. All state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- IF_ID_RegisterRs1  input  5  rs1 field of the instruction in ID.
- IF_ID_RegisterRs2  input  5  rs2 field of the instruction in ID.
- ID_EX_RegisterRd  input  5  rd field of the instruction in EX.
- ID_EX_MemRead  input  1  the instruction in EX is a load.
- zero  input  1  branch-taken indication from EX (1 = taken).
- PCWrite  output  1  1 = PC may update; 0 = hold PC.
- IF_ID_Write  output  1  1 = IF/ID register may load; 0 = hold it.
- ControlMuxSel  output  1  1 = zero the ID control bits, inserting a bubble into ID/EX.
- IF_Flush  output  1  1 = clear the IF/ID register to a NOP.
- stall_cnt  output  CNT_W  number of load-use stall cycles since reset; saturates at all-ones.
- flush_cnt  output  CNT_W  number of flush cycles since reset; saturates at all-ones.

## Operation
- load_use = ID_EX_MemRead && ID_EX_RegisterRd != 0 && (ID_EX_RegisterRd == IF_ID_RegisterRs1 || ID_EX_RegisterRd == IF_ID_RegisterRs2).
- A load targeting x0 never stalls.
- Priority: branch flush, then load-use stall, then normal.
- Branch (zero = 1), regardless of load_use:
  - IF_Flush = 1, ControlMuxSel = 1.
  - PCWrite = 1, IF_ID_Write = 1.
  - The wrong-path instruction in ID is bubbled, not stalled.
- Stall (zero = 0, load_use = 1):
  - PCWrite = 0, IF_ID_Write = 0.
  - ControlMuxSel = 1, IF_Flush = 0.
- Normal:
  - PCWrite = 1, IF_ID_Write = 1.
  - ControlMuxSel = 0, IF_Flush = 0.
- While rst = 1: outputs take their normal values (1, 1, 0, 0) regardless of inputs.
- Counters:
  - stall_cnt increments on each clock edge where the stall condition holds and rst = 0.
  - flush_cnt does the same for the branch condition.
  - Each saturates at 2^CNT_W − 1 and does not wrap.
  - A cycle in which both conditions are true counts only as a flush.

## Timing
- Control outputs are purely combinational, valid in the same cycle as their inputs; zero cycles of latency.
- No internal state affects the control outputs. A sustained load_use keeps the stall asserted for as long as it persists; the pipeline deasserts ID_EX_MemRead once the bubble advances.
- Counters are registered: the value is visible the cycle after the qualifying edge.
- Reset:
  - rst sampled high sets stall_cnt = 0 and flush_cnt = 0 at that edge.
  - Asserting reset mid-stall forces the normal outputs immediately.
  - Asserting reset mid-stall also drops that cycle's counter increment.
- X inputs are not filtered. Inputs are stable before the clock edge per the standard pipeline timing.

## Structure
- Shared package `hazard_pkg`:
  - localparam REG_X0 = 5'd0.
  - typedef struct `hazard_ctrl_t` {pc_write, if_id_write, ctrl_mux_sel, if_flush}.
  - Constants for the NORMAL, STALL and FLUSH control encodings.
- One natural sub-module: `sat_counter` (parameter W; inputs clk, rst, inc; output count), instantiated twice.
- Top-level logic: compute load_use, select the control encoding by priority, drive the counter increments.

## Test plan
- No hazard: rs1 = 1, rs2 = 2, rd = 3, MemRead = 0, zero = 0 → PCWrite = 1, IF_ID_Write = 1, ControlMuxSel = 0, IF_Flush = 0; counters unchanged.
- Branch taken: same operands, zero = 1 for 1 cycle → IF_Flush = 1, ControlMuxSel = 1, PCWrite = 1; flush_cnt becomes 1 the next cycle.
- Load-use on rs1: rs1 = 1, rs2 = 2, rd = 1, MemRead = 1, zero = 0 for 2 cycles → PCWrite = 0, IF_ID_Write = 0, ControlMuxSel = 1, IF_Flush = 0; stall_cnt becomes 2.
- rd match without a load: rs1 = 6, rs2 = 5, rd = 6, MemRead = 0 → no stall.
  - Then set zero = 1 → flush outputs.
  - Then rd = 0 with MemRead = 1 and rs1 = 0 → no stall.
- Simultaneous events: load_use true and zero = 1 → flush encoding; flush_cnt increments, stall_cnt does not.
- Reset behaviour:
  - rst = 1 during a load-use → normal outputs, counters cleared to 0.
  - With CNT_W = 2 and 5 stall cycles → stall_cnt holds at 3.
